// File: rtl/sa_pkg.sv
// Shared definitions for the output-stationary systolic array.
// Holds the drain FSM encoding and the default operand/accumulator widths.
package sa_pkg;

  typedef enum logic {
    SA_IDLE  = 1'b0,
    SA_DRAIN = 1'b1
  } sa_state_t;

  localparam int SA_DATA_WIDTH = 16;
  localparam int SA_ACC_WIDTH  = 32;

endpackage

// File: rtl/sa_pe.sv
// Output-stationary processing element: signed MAC into a local accumulator,
// one-register forwarding of A (right) and B (down), and the drain shift.
module sa_pe
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = SA_DATA_WIDTH,
  parameter int ACC_WIDTH  = SA_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  drain_mode,
  input  logic                  clr,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic                  a_en_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  b_en_in,
  input  logic [ACC_WIDTH-1:0]  acc_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic                  a_en_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  b_en_out,
  output logic [ACC_WIDTH-1:0]  acc_out
);

  logic [DATA_WIDTH-1:0]       a_reg;
  logic                        a_en_reg;
  logic [DATA_WIDTH-1:0]       b_reg;
  logic                        b_en_reg;
  logic [ACC_WIDTH-1:0]        acc_reg;
  logic                        a_en_eff;
  logic                        b_en_eff;
  logic                        mac_fire;
  logic signed [ACC_WIDTH-1:0] a_ext;
  logic signed [ACC_WIDTH-1:0] b_ext;
  logic signed [ACC_WIDTH-1:0] prod;

  // While draining, operand enables are squashed both here and downstream.
  assign a_en_eff = a_en_in & ~drain_mode;
  assign b_en_eff = b_en_in & ~drain_mode;
  assign mac_fire = a_en_eff & b_en_eff;

  // Operands are sign-extended first so the product wraps at ACC_WIDTH.
  assign a_ext = ACC_WIDTH'($signed(a_in));
  assign b_ext = ACC_WIDTH'($signed(b_in));
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk) begin
    if (srst) begin
      a_reg    <= '0;
      a_en_reg <= 1'b0;
      b_reg    <= '0;
      b_en_reg <= 1'b0;
      acc_reg  <= '0;
    end else begin
      a_reg    <= a_in;
      a_en_reg <= a_en_eff;
      b_reg    <= b_in;
      b_en_reg <= b_en_eff;
      if (shift) begin
        acc_reg <= acc_in;
      end else if (clr) begin
        acc_reg <= '0;
      end else if (mac_fire) begin
        acc_reg <= acc_reg + prod;
      end
    end
  end

  assign a_out    = a_reg;
  assign a_en_out = a_en_reg;
  assign b_out    = b_reg;
  assign b_en_out = b_en_reg;
  assign acc_out  = acc_reg;

endmodule

// File: rtl/systolic_array_nxm.sv
// ROWS x COLS output-stationary systolic array with a row-by-row drain port.
// Results leave from the bottom row; each accepted beat shifts every row down.
module systolic_array_nxm
  import sa_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = SA_DATA_WIDTH,
  parameter int ACC_WIDTH  = SA_ACC_WIDTH
) (
  input  logic                       array_clk,
  input  logic                       array_rst,
  input  logic                       array_clr,
  input  logic [ROWS-1:0]            array_left_en,
  input  logic [ROWS*DATA_WIDTH-1:0] array_left_data,
  input  logic [COLS-1:0]            array_up_en,
  input  logic [COLS*DATA_WIDTH-1:0] array_up_data,
  input  logic                       array_drain,
  input  logic                       array_out_ready,
  output logic                       array_out_valid,
  output logic [COLS*ACC_WIDTH-1:0]  array_out_data,
  output logic                       array_busy
);

  localparam int CNT_W = $clog2(ROWS) + 1;

  sa_state_t        state_reg;
  sa_state_t        state_next;
  logic [CNT_W-1:0] beat_cnt_reg;
  logic [CNT_W-1:0] beat_cnt_next;
  logic             draining;
  logic             beat_fire;
  logic             clr_idle;

  always_ff @(posedge array_clk) begin
    if (array_rst) begin
      state_reg    <= SA_IDLE;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      SA_IDLE: begin
        if (array_drain) begin
          state_next    = SA_DRAIN;
          beat_cnt_next = '0;
        end
      end
      SA_DRAIN: begin
        if (array_out_ready) begin
          if (beat_cnt_reg == CNT_W'(ROWS - 1)) begin
            state_next    = SA_IDLE;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next    = SA_IDLE;
        beat_cnt_next = '0;
      end
    endcase
  end

  assign draining        = (state_reg == SA_DRAIN);
  assign beat_fire       = draining & array_out_ready;
  assign clr_idle        = array_clr & ~draining;
  assign array_busy      = draining;
  assign array_out_valid = draining;

  // Mesh nets: column COLS / row ROWS entries are the far-edge outputs.
  // acc_bus[0] is the zero fed into row 0 on a drain shift.
  logic [DATA_WIDTH-1:0] a_bus    [ROWS][COLS+1];
  logic                  a_en_bus [ROWS][COLS+1];
  logic [DATA_WIDTH-1:0] b_bus    [ROWS+1][COLS];
  logic                  b_en_bus [ROWS+1][COLS];
  logic [ACC_WIDTH-1:0]  acc_bus  [ROWS+1][COLS];

  genvar gi, gj;

  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row_edge
      logic unused_a_edge;
      assign a_bus[gi][0]    = array_left_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign a_en_bus[gi][0] = array_left_en[gi];
      // Operands leaving the right edge have no consumer.
      assign unused_a_edge   = ^{a_bus[gi][COLS], a_en_bus[gi][COLS]};
    end

    for (gj = 0; gj < COLS; gj++) begin : g_col_edge
      logic unused_b_edge;
      assign b_bus[0][gj]    = array_up_data[gj*DATA_WIDTH +: DATA_WIDTH];
      assign b_en_bus[0][gj] = array_up_en[gj];
      assign acc_bus[0][gj]  = '0;
      assign unused_b_edge   = ^{b_bus[ROWS][gj], b_en_bus[ROWS][gj]};
      assign array_out_data[gj*ACC_WIDTH +: ACC_WIDTH] =
        draining ? acc_bus[ROWS][gj] : '0;
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_row
      for (gj = 0; gj < COLS; gj++) begin : g_col
        sa_pe #(
          .DATA_WIDTH (DATA_WIDTH),
          .ACC_WIDTH  (ACC_WIDTH)
        ) u_pe (
          .clk        (array_clk),
          .srst       (array_rst),
          .drain_mode (draining),
          .clr        (clr_idle),
          .shift      (beat_fire),
          .a_in       (a_bus[gi][gj]),
          .a_en_in    (a_en_bus[gi][gj]),
          .b_in       (b_bus[gi][gj]),
          .b_en_in    (b_en_bus[gi][gj]),
          .acc_in     (acc_bus[gi][gj]),
          .a_out      (a_bus[gi][gj+1]),
          .a_en_out   (a_en_bus[gi][gj+1]),
          .b_out      (b_bus[gi+1][gj]),
          .b_en_out   (b_en_bus[gi+1][gj]),
          .acc_out    (acc_bus[gi+1][gj])
        );
      end
    end
  endgenerate

endmodule

// File: tb/tb_systolic_array_nxm.sv
// Directed bench for the 4x4 systolic array: GEMM, drain, backpressure,
// arithmetic wrap, clear/enable rules and reset during a drain.
module tb_systolic_array_nxm;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 16;
  localparam int AW   = 32;
  localparam int OW   = COLS * AW;

  logic                 array_clk = 1'b0;
  logic                 array_rst;
  logic                 array_clr;
  logic [ROWS-1:0]      array_left_en;
  logic [ROWS*DW-1:0]   array_left_data;
  logic [COLS-1:0]      array_up_en;
  logic [COLS*DW-1:0]   array_up_data;
  logic                 array_drain;
  logic                 array_out_ready;
  logic                 array_out_valid;
  logic [OW-1:0]        array_out_data;
  logic                 array_busy;

  int total = 0;
  int bad   = 0;

  systolic_array_nxm #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW)
  ) dut (
    .array_clk       (array_clk),
    .array_rst       (array_rst),
    .array_clr       (array_clr),
    .array_left_en   (array_left_en),
    .array_left_data (array_left_data),
    .array_up_en     (array_up_en),
    .array_up_data   (array_up_data),
    .array_drain     (array_drain),
    .array_out_ready (array_out_ready),
    .array_out_valid (array_out_valid),
    .array_out_data  (array_out_data),
    .array_busy      (array_busy)
  );

  always #5 array_clk = ~array_clk;

  function automatic logic [OW-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
    return {32'(v3), 32'(v2), 32'(v1), 32'(v0)};
  endfunction

  task automatic idle_inputs();
    array_clr       = 1'b0;
    array_left_en   = '0;
    array_left_data = '0;
    array_up_en     = '0;
    array_up_data   = '0;
    array_drain     = 1'b0;
  endtask

  // Skewed injection: row r gets A[r][t-r], column c gets B[t-c][c].
  task automatic inject(input int a [4][4], input int b [4][4]);
    for (int t = 0; t < 12; t++) begin
      @(negedge array_clk);
      for (int r = 0; r < ROWS; r++) begin
        int k = t - r;
        array_left_en[r] = (k >= 0 && k < 4);
        array_left_data[r*DW +: DW] = (k >= 0 && k < 4) ? 16'(a[r][k]) : 16'd0;
      end
      for (int c = 0; c < COLS; c++) begin
        int k = t - c;
        array_up_en[c] = (k >= 0 && k < 4);
        array_up_data[c*DW +: DW] = (k >= 0 && k < 4) ? 16'(b[k][c]) : 16'd0;
      end
    end
    @(negedge array_clk);
    idle_inputs();
    repeat (2) @(negedge array_clk);
  endtask

  // One cycle of stimulus on row 0 / column 0 only.
  task automatic drive00(input int a, input int b, input bit len, input bit uen, input bit clr);
    @(negedge array_clk);
    idle_inputs();
    array_left_en[0]        = len;
    array_left_data[DW-1:0] = 16'(a);
    array_up_en[0]          = uen;
    array_up_data[DW-1:0]   = 16'(b);
    array_clr               = clr;
  endtask

  task automatic settle();
    @(negedge array_clk);
    idle_inputs();
    repeat (2) @(negedge array_clk);
  endtask

  // Runs a drain and collects beats; stall/poke/reset insertion is optional (-1 = off).
  task automatic do_drain(input int stall_after, input int stall_len, input int poke_at,
                          input int rst_at, output logic [OW-1:0] beats [4],
                          output int nbeats, output int busy_cycles, output int unstable,
                          output int vbad, output bit timed_out);
    int cyc;
    int stalled;
    logic [OW-1:0] held;
    for (int i = 0; i < ROWS; i++) beats[i] = '0;
    nbeats = 0; busy_cycles = 0; unstable = 0; vbad = 0; timed_out = 1'b0;
    cyc = 0; stalled = 0; held = '0;
    @(negedge array_clk);
    idle_inputs();
    array_drain     = 1'b1;
    array_out_ready = 1'b1;
    @(negedge array_clk);
    array_drain = 1'b0;
    while (array_busy && cyc < 64) begin
      busy_cycles++;
      idle_inputs();
      if (array_out_valid !== 1'b1) vbad++;
      if (nbeats == rst_at) begin
        array_rst = 1'b1;
        return;
      end
      if (nbeats == stall_after && stalled < stall_len) begin
        if (stalled == 0) held = array_out_data;
        else if (array_out_data !== held) unstable++;
        array_out_ready = 1'b0;
        stalled++;
      end else begin
        if (stalled != 0 && nbeats == stall_after && array_out_data !== held) unstable++;
        array_out_ready = 1'b1;
        if (nbeats == poke_at) begin
          array_clr       = 1'b1;
          array_drain     = 1'b1;
          array_left_en   = '1;
          array_left_data = {4{16'd1}};
          array_up_en     = '1;
          array_up_data   = {4{16'd1}};
        end
        if (nbeats < ROWS) beats[nbeats] = array_out_data;
        nbeats++;
      end
      @(negedge array_clk);
      cyc++;
    end
    idle_inputs();
    array_out_ready = 1'b1;
    timed_out = (cyc >= 64);
  endtask

  int a_mat   [4][4] = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 10, 11, 12}, '{13, 14, 15, 16}};
  int eye_mat [4][4] = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 1}};
  int diag_mat[4][4] = '{'{2, 0, 0, 0}, '{0, -1, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 3}};

  task automatic test_reset();
    array_rst = 1'b1;
    idle_inputs();
    array_out_ready = 1'b1;
    repeat (3) @(negedge array_clk);
    total++; if (array_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", array_out_valid); end
    total++; if (array_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", array_busy); end
    total++; if (array_out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", array_out_data); end
    array_rst = 1'b0;
    $display("reset: valid=%b busy=%b data=%h", array_out_valid, array_busy, array_out_data);
  endtask

  task automatic test_drain_zero();
    logic [OW-1:0] beats [4];
    int nb, bc, us, vb;
    bit to;
    do_drain(-1, 0, -1, -1, beats, nb, bc, us, vb, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL zero_drain_timeout got=%0d want=0", to); end
    total++; if (nb != 4) begin bad++; $display("FAIL zero_drain_beats got=%0d want=4", nb); end
    total++; if (bc != 4) begin bad++; $display("FAIL zero_drain_busy_cycles got=%0d want=4", bc); end
    total++; if (vb != 0) begin bad++; $display("FAIL zero_drain_valid got=%0d low cycles want=0", vb); end
    for (int k = 0; k < 4; k++) begin
      total++; if (beats[k] !== '0) begin bad++; $display("FAIL zero_drain_beat%0d got=%h want=0", k, beats[k]); end
    end
    total++; if (array_out_valid !== 1'b0 || array_busy !== 1'b0) begin
      bad++; $display("FAIL zero_drain_idle got valid=%b busy=%b want 0/0", array_out_valid, array_busy);
    end
    $display("drain_zero: beats=%0d busy_cycles=%0d", nb, bc);
  endtask

  task automatic test_gemm();
    logic [OW-1:0] beats [4];
    logic [OW-1:0] exp_b [4];
    int nb, bc, us, vb;
    bit to;
    exp_b[0] = pack4(13, 14, 15, 16);
    exp_b[1] = pack4(9, 10, 11, 12);
    exp_b[2] = pack4(5, 6, 7, 8);
    exp_b[3] = pack4(1, 2, 3, 4);
    inject(a_mat, eye_mat);
    do_drain(-1, 0, -1, -1, beats, nb, bc, us, vb, to);
    total++; if (nb != 4) begin bad++; $display("FAIL gemm_beats got=%0d want=4", nb); end
    for (int k = 0; k < 4; k++) begin
      total++; if (beats[k] !== exp_b[k]) begin bad++; $display("FAIL gemm_beat%0d got=%h want=%h", k, beats[k], exp_b[k]); end
      $display("gemm beat%0d: %h", k, beats[k]);
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] beats [4];
    logic [OW-1:0] exp_b [4];
    int nb, bc, us, vb;
    bit to;
    exp_b[0] = pack4(26, -14, 0, 48);
    exp_b[1] = pack4(18, -10, 0, 36);
    exp_b[2] = pack4(10, -6, 0, 24);
    exp_b[3] = pack4(2, -2, 0, 12);
    inject(a_mat, diag_mat);
    do_drain(-1, 0, -1, -1, beats, nb, bc, us, vb, to);
    total++; if (bc != 4) begin bad++; $display("FAIL b2b_busy_cycles got=%0d want=4", bc); end
    for (int k = 0; k < 4; k++) begin
      total++; if (beats[k] !== exp_b[k]) begin bad++; $display("FAIL b2b_beat%0d got=%h want=%h", k, beats[k], exp_b[k]); end
      $display("b2b beat%0d: %h", k, beats[k]);
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] beats [4];
    logic [OW-1:0] exp_b [4];
    int nb, bc, us, vb;
    bit to;
    exp_b[0] = pack4(13, 14, 15, 16);
    exp_b[1] = pack4(9, 10, 11, 12);
    exp_b[2] = pack4(5, 6, 7, 8);
    exp_b[3] = pack4(1, 2, 3, 4);
    inject(a_mat, eye_mat);
    do_drain(1, 3, -1, -1, beats, nb, bc, us, vb, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL bp_timeout got=%0d want=0", to); end
    total++; if (nb != 4) begin bad++; $display("FAIL bp_beats got=%0d want=4", nb); end
    total++; if (bc != 7) begin bad++; $display("FAIL bp_busy_cycles got=%0d want=7", bc); end
    total++; if (us != 0) begin bad++; $display("FAIL bp_stable got=%0d changes want=0", us); end
    total++; if (vb != 0) begin bad++; $display("FAIL bp_valid got=%0d low cycles want=0", vb); end
    for (int k = 0; k < 4; k++) begin
      total++; if (beats[k] !== exp_b[k]) begin bad++; $display("FAIL bp_beat%0d got=%h want=%h", k, beats[k], exp_b[k]); end
    end
    $display("backpressure: beats=%0d busy_cycles=%0d", nb, bc);
  endtask

  task automatic test_arith();
    logic [OW-1:0] beats [4];
    int nb, bc, us, vb;
    bit to;
    drive00(-3, 5, 1'b1, 1'b1, 1'b0);
    settle();
    do_drain(-1, 0, -1, -1, beats, nb, bc, us, vb, to);
    total++; if (beats[3] !== {96'd0, 32'hFFFF_FFF1}) begin
      bad++; $display("FAIL arith_neg got=%h want=%h", beats[3], {96'd0, 32'hFFFF_FFF1});
    end
    $display("arith -3*5: %h", beats[3]);
    // 0x40000000 + 0x3FFF0001 + 0xFFFE = 0x7FFFFFFF, then +1 wraps.
    drive00(-32768, -32768, 1'b1, 1'b1, 1'b0);
    drive00(32767, 32767, 1'b1, 1'b1, 1'b0);
    drive00(32767, 2, 1'b1, 1'b1, 1'b0);
    drive00(1, 1, 1'b1, 1'b1, 1'b0);
    settle();
    do_drain(-1, 0, -1, -1, beats, nb, bc, us, vb, to);
    total++; if (beats[3] !== {96'd0, 32'h8000_0000}) begin
      bad++; $display("FAIL arith_wrap got=%h want=%h", beats[3], {96'd0, 32'h8000_0000});
    end
    $display("arith wrap: %h", beats[3]);
  endtask

  task automatic test_clear_enables();
    logic [OW-1:0] beats [4];
    logic [OW-1:0] exp_b [4];
    int nb, bc, us, vb, nz;
    bit to;
    drive00(4, 4, 1'b1, 1'b1, 1'b0);
    drive00(9, 9, 1'b1, 1'b1, 1'b1);
    settle();
    do_drain(-1, 0, -1, -1, beats, nb, bc, us, vb, to);
    total++; if (beats[3] !== '0) begin bad++; $display("FAIL clr_over_mac got=%h want=0", beats[3]); end
    $display("clr+mac: %h", beats[3]);
    drive00(2, 3, 1'b1, 1'b1, 1'b0);
    drive00(100, 100, 1'b1, 1'b0, 1'b0);
    settle();
    do_drain(-1, 0, -1, -1, beats, nb, bc, us, vb, to);
    total++; if (beats[3] !== pack4(6, 0, 0, 0)) begin
      bad++; $display("FAIL left_only got=%h want=%h", beats[3], pack4(6, 0, 0, 0));
    end
    $display("left-only: %h", beats[3]);
    exp_b[0] = pack4(13, 14, 15, 16);
    exp_b[1] = pack4(9, 10, 11, 12);
    exp_b[2] = pack4(5, 6, 7, 8);
    exp_b[3] = pack4(1, 2, 3, 4);
    inject(a_mat, eye_mat);
    do_drain(-1, 0, 1, -1, beats, nb, bc, us, vb, to);
    total++; if (nb != 4 || bc != 4) begin
      bad++; $display("FAIL poke_drain_len got beats=%0d busy=%0d want 4/4", nb, bc);
    end
    for (int k = 0; k < 4; k++) begin
      total++; if (beats[k] !== exp_b[k]) begin bad++; $display("FAIL poke_beat%0d got=%h want=%h", k, beats[k], exp_b[k]); end
    end
    do_drain(-1, 0, -1, -1, beats, nb, bc, us, vb, to);
    nz = 0;
    for (int k = 0; k < 4; k++) if (beats[k] !== '0) nz++;
    total++; if (nz != 0) begin bad++; $display("FAIL poke_leak got=%0d nonzero beats want=0", nz); end
    $display("clear/enables: poke drain beats=%0d", nb);
  endtask

  task automatic test_reset_mid_drain();
    logic [OW-1:0] beats [4];
    int nb, bc, us, vb, nz;
    bit to;
    inject(a_mat, eye_mat);
    do_drain(-1, 0, -1, 2, beats, nb, bc, us, vb, to);
    total++; if (nb != 2) begin bad++; $display("FAIL midrst_beats got=%0d want=2", nb); end
    @(negedge array_clk);
    total++; if (array_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", array_out_valid); end
    total++; if (array_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", array_busy); end
    total++; if (array_out_data !== '0) begin bad++; $display("FAIL midrst_data got=%h want=0", array_out_data); end
    array_rst = 1'b0;
    do_drain(-1, 0, -1, -1, beats, nb, bc, us, vb, to);
    nz = 0;
    for (int k = 0; k < 4; k++) if (beats[k] !== '0) nz++;
    total++; if (nb != 4 || nz != 0) begin
      bad++; $display("FAIL midrst_redrain got beats=%0d nonzero=%0d want 4/0", nb, nz);
    end
    $display("reset mid-drain: redrain beats=%0d nonzero=%0d", nb, nz);
  endtask

  initial begin
    test_reset();
    test_drain_zero();
    test_gemm();
    test_back_to_back();
    test_backpressure();
    test_arith();
    test_clear_enables();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_array_nxm.md
SYSTOLIC_ARRAY_NXM -- requirements
Module: systolic_array_nxm

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of PE rows (>=2).
REQ-002 SHALL have parameter COLS, default 4, number of PE columns (>=2).
REQ-003 SHALL have parameter DATA_WIDTH, default 16, signed operand width.
REQ-004 SHALL have parameter ACC_WIDTH, default 32, signed accumulator width (>= 2*DATA_WIDTH).
REQ-005 SHALL use one clock, array_clk; reset array_rst is synchronous and active-high.
REQ-006 array_clk  in  1  clock, rising edge.
REQ-007 array_rst  in  1  synchronous active-high reset.
REQ-008 array_clr  in  1  zero all accumulators.
REQ-009 array_left_en  in  ROWS  operand-A valid, bit r = row r.
REQ-010 array_left_data  in  ROWS*DATA_WIDTH  operand A, slice r = row r.
REQ-011 array_up_en  in  COLS  operand-B valid, bit c = column c.
REQ-012 array_up_data  in  COLS*DATA_WIDTH  operand B, slice c = column c.
REQ-013 array_drain  in  1  request result readout.
REQ-014 array_out_ready  in  1  downstream accepts a result beat.
REQ-015 array_out_valid  out  1  result beat valid.
REQ-016 array_out_data  out  COLS*ACC_WIDTH  one accumulator row, slice c = column c.
REQ-017 array_busy  out  1  high while draining.

Function
REQ-018 SHALL be output-stationary: PE(r,c) holds one ACC_WIDTH accumulator.
REQ-019 PE(r,c) SHALL forward A (data+en) right and B (data+en) down through one register each, so A injected to row r at cycle t is used by PE(r,c) at cycle t+c, and B injected to column c at cycle t is used by PE(r,c) at cycle t+r.
REQ-020 PE SHALL accumulate acc += signed(A)*signed(B), registered, only when both incoming enables are high; one enable alone SHALL leave acc unchanged but still forward.
REQ-021 Accumulation SHALL wrap modulo 2^ACC_WIDTH (two's complement), with no saturation.
REQ-022 FSM states SHALL be IDLE and DRAIN; array_drain in IDLE SHALL enter DRAIN next cycle and clear the beat counter; array_drain in DRAIN SHALL be ignored.
REQ-023 In DRAIN, array_out_valid SHALL be 1 and array_out_data SHALL show the bottom-row accumulators combinationally.
REQ-024 On each beat with valid&&ready, every row SHALL shift its accumulators down one row, with row 0 loading zero; beat k SHALL carry the original row ROWS-1-k.
REQ-025 When out_ready is low, the array SHALL stall, holding data and counter stable.
REQ-026 After ROWS accepted beats, the FSM SHALL return to IDLE and all accumulators SHALL be zero.
REQ-027 In DRAIN, input enables SHALL be treated as 0, with no MAC. Forwarding registers SHALL still shift, carrying 0 enables.
REQ-028 array_clr in IDLE SHALL zero all accumulators next cycle, taking priority over a simultaneous MAC. array_clr SHALL be ignored in DRAIN.
REQ-029 array_busy SHALL equal (state==DRAIN); array_out_valid SHALL be 0 in IDLE.

Reset
REQ-030 On array_rst: state IDLE, beat counter 0, all accumulators 0, all forwarding data and enable registers 0, array_out_valid 0, array_busy 0, array_out_data 0.
REQ-031 Reset asserted mid-DRAIN SHALL abort the drain; outputs SHALL be at reset values the following cycle.

Structure
REQ-032 FSM state encodings and default ACC_WIDTH SHALL live in a shared package/header, sa_pkg.
REQ-033 A single sub-module, sa_pe, SHALL implement MAC, forwarding, and drain shift; the top SHALL instantiate it ROWS x COLS via generate.
REQ-034 The beat counter SHALL be $clog2(ROWS)+1 bits wide.

Verification
REQ-035 Reset, then drain with ready=1: 4 beats of all zeros, busy high exactly 4 cycles, then IDLE.
REQ-036 4x4 GEMM, A=[[1..4],[5..8],[9..12],[13..16]], B=identity, row r and column c skewed by r and c cycles respectively: drain beats are [13,14,15,16], [9..12], [5..8], [1..4].
REQ-037 Backpressure: out_ready low 3 cycles after beat 1: data held stable, no beat lost or duplicated, 4 beats total.
REQ-038 Arithmetic: A=-3 and B=5 give -15. An acc preloaded via MACs to 0x7FFFFFFF, plus 1*1, gives 0x80000000.
REQ-039 Clear and enables: clr coincident with MAC gives acc 0; left_en=1 with up_en=0 leaves acc unchanged; clr and drain during DRAIN are ignored.
REQ-040 Reset mid-drain after beat 2: out_valid 0 next cycle; a subsequent drain returns all-zero beats.
